fifo_wr_ctrl: RTL and testbench
===============================

Name: fifo_wr_ctrl

Overview:
Write-side controller for the UART async FIFO. It sequences the external dual gray-coded write-pointer counter by driving its enable. It generates the memory write strobe and address, synchronizes the read-domain gray pointer, and produces registered full, almost-full, fill-level and overflow status. It sits between the UART host/RX write requester and the dual-port FIFO RAM.

Parameters:
ADDR_SIZE, 8, RAM address width; pointers are ADDR_SIZE+1 bits (MSB = wrap bit); depth 2^ADDR_SIZE = 256.
AFULL_THRESH, 240, fill level at or above which almost_full asserts (range 1..256).
SYNC_STAGES, 2, flop stages in the read-pointer synchronizer (minimum 2).

Ports:
clk  in  1  write-domain clock
reset_n  in  1  asynchronous active-low reset
wr_req  in  1  write request; held with wr_data until wr_ack
wr_data  in  8  write data
wr_ack  out  1  request accepted this cycle (combinational)
cnt_en  out  1  enable to the write-pointer gray counter
wptr_gray  in  9  current 9-bit gray write pointer from the counter
rptr_gray_async  in  9  9-bit gray read pointer from the read clock domain
mem_we  out  1  RAM write strobe
mem_waddr  out  8  RAM write address
mem_wdata  out  8  RAM write data
full  out  1  FIFO full (registered)
almost_full  out  1  level >= AFULL_THRESH (registered)
wr_level  out  9  fill level 0..256 (registered, pessimistic)
overflow  out  1  sticky: write attempted while full
ovf_clr  in  1  clears overflow (and drop_cnt if present)

Behaviour:
- Reset (reset_n low, async): full=0, almost_full=0, wr_level=0, overflow=0, all synchronizer flops=0. The counter shares reset_n. The read side must be reset together with this block, because a mid-operation reset discards contents and the pointers restart at 0.
- accept = wr_req & ~full. wr_ack = cnt_en = mem_we = accept, all combinational, same cycle.
- mem_wdata = wr_data.
- wbin = gray2bin(wptr_gray). mem_waddr = wbin[7:0]. The RAM captures the data at the same edge that advances the counter.
- Synchronizer: rptr_gray_async passes through SYNC_STAGES flops to give rq. rbin = gray2bin(rq).
- Next-state values:
  - wbin_next = wbin + accept (9-bit, wraps 511->0).
  - wgray_next = wbin_next ^ (wbin_next>>1).
- Registered each edge:
  - full <= (wgray_next == {~rq[8:7], rq[6:0]}).
  - wr_level <= (wbin_next - rbin) mod 512.
  - almost_full <= (wbin_next - rbin) mod 512 >= AFULL_THRESH.
- full/level/almost_full therefore track the counter's new value in the cycle after accept. No accept can occur while full=1.
- Latency of read-pointer updates: SYNC_STAGES+1 cycles until full/level reflect a read. Level is pessimistic (never under-reports fill).
- Empty boundary: level 0 when wbin == rbin. Full boundary: level 256 exactly when full=1.
- Wrap: pointer wrap 511->0 handled by the modulo-512 subtraction and the MSB/2nd-MSB gray compare.
- overflow: set when wr_req & full. Cleared by ovf_clr. If set and clear occur in the same cycle, set wins.
- Simultaneous read-drain and write when full: the write is rejected. Full deasserts only after the synchronized read pointer moves.

Optional Feature:
Macro WR_DROP_CNT_EN.
- Defined: adds output drop_cnt [7:0]. It increments on each cycle with wr_req & full and saturates at 255. Reset value 0. ovf_clr zeroes it; on the same cycle as a drop, the clear wins and the result is 0.
- Undefined: the port and logic are absent; only the sticky overflow is provided.

Test Plan:
1. Reset then idle, rptr=0 -> full=0, almost_full=0, wr_level=0, overflow=0, cnt_en=0.
2. 240 consecutive wr_req, rptr held 0 -> mem_waddr 0..239 in order. The cycle after the 240th accept gives wr_level=240 and almost_full=1; full stays 0.
3. Continue to 256 writes -> full=1 and wr_level=256 the cycle after the 256th accept. A 257th wr_req gives wr_ack=0, mem_we=0 and overflow=1 (drop_cnt=1 if enabled).
4. While full, drive rptr_gray_async=gray(1)=9'h001 -> full=0 and wr_level=255 exactly SYNC_STAGES+1 cycles later. The next wr_req is accepted with mem_waddr=0.
5. Wrap: preload by writing/reading past 511. Pointers at wbin=510, rbin=510, then 4 writes -> mem_waddr 254,255,0,1; wr_level=4; full=0.
6. overflow=1 with ovf_clr and wr_req&full in the same cycle -> overflow stays 1. With ovf_clr alone -> overflow=0. Async reset mid-burst -> all outputs 0 immediately.

Source files
------------

// File: rtl/fifo_wr_ctrl_if.sv
// Write-side bus of the UART async FIFO: requester handshake, gray write pointer, RAM write port.
// The slave modport belongs to fifo_wr_ctrl; the master modport belongs to the requester, counter and RAM side.
interface fifo_wr_ctrl_if #(
  parameter int ADDR_SIZE = 8
);
  logic                 wr_req;
  logic [7:0]           wr_data;
  logic                 wr_ack;
  logic                 cnt_en;
  logic [ADDR_SIZE:0]   wptr_gray;
  logic                 mem_we;
  logic [ADDR_SIZE-1:0] mem_waddr;
  logic [7:0]           mem_wdata;

  modport master (
    output wr_req, wr_data, wptr_gray,
    input  wr_ack, cnt_en, mem_we, mem_waddr, mem_wdata
  );

  modport slave (
    input  wr_req, wr_data, wptr_gray,
    output wr_ack, cnt_en, mem_we, mem_waddr, mem_wdata
  );
endinterface

// File: rtl/fifo_wr_ctrl.sv
// Write controller for the UART async FIFO: accept/strobe is combinational; full, level and almost_full register one cycle after accept.
// Requests stall while full, and a read shows up SYNC_STAGES+1 cycles later; WR_DROP_CNT_EN adds a saturating drop counter.
module fifo_wr_ctrl #(
  parameter int ADDR_SIZE    = 8,
  parameter int AFULL_THRESH = 240,
  parameter int SYNC_STAGES  = 2
) (
  input  logic               clk,
  input  logic               reset_n,
  fifo_wr_ctrl_if.slave      wr,
  input  logic [ADDR_SIZE:0] rptr_gray_async,
  input  logic               ovf_clr,
  output logic               full,
  output logic               almost_full,
  output logic [ADDR_SIZE:0] wr_level,
  output logic               overflow
`ifdef WR_DROP_CNT_EN
  ,
  output logic [7:0]         drop_cnt
`endif
);

  localparam int PW = ADDR_SIZE + 1;

  function automatic logic [PW-1:0] gray2bin(input logic [PW-1:0] g);
    logic [PW-1:0] b;
    b[PW-1] = g[PW-1];
    for (int i = PW - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  logic [PW-1:0] sync_q [SYNC_STAGES];
  logic [PW-1:0] rq;
  logic [PW-1:0] rbin;
  logic [PW-1:0] wbin;
  logic [PW-1:0] wbin_next;
  logic [PW-1:0] wgray_next;
  logic [PW-1:0] level_next;
  logic          accept;
  logic          drop;
  logic          full_next;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        sync_q[i] <= '0;
      end
    end else begin
      sync_q[0] <= rptr_gray_async;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
    end
  end

  assign rq = sync_q[SYNC_STAGES-1];

  always_comb begin
    accept     = wr.wr_req & ~full;
    drop       = wr.wr_req & full;
    wbin       = gray2bin(wr.wptr_gray);
    rbin       = gray2bin(rq);
    wbin_next  = wbin + {{ADDR_SIZE{1'b0}}, accept};
    wgray_next = wbin_next ^ (wbin_next >> 1);
    // Mod-2^PW difference: a stale read pointer can only over-report fill.
    level_next = wbin_next - rbin;
    full_next  = (wgray_next == {~rq[PW-1:PW-2], rq[PW-3:0]});
  end

  assign wr.wr_ack    = accept;
  assign wr.cnt_en    = accept;
  assign wr.mem_we    = accept;
  assign wr.mem_waddr = wbin[ADDR_SIZE-1:0];
  assign wr.mem_wdata = wr.wr_data;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      full        <= 1'b0;
      almost_full <= 1'b0;
      wr_level    <= '0;
    end else begin
      full        <= full_next;
      almost_full <= (level_next >= PW'(AFULL_THRESH));
      wr_level    <= level_next;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      overflow <= 1'b0;
    end else if (drop) begin
      overflow <= 1'b1;
    end else if (ovf_clr) begin
      overflow <= 1'b0;
    end
  end

`ifdef WR_DROP_CNT_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      drop_cnt <= 8'd0;
    end else if (ovf_clr) begin
      drop_cnt <= 8'd0;
    end else if (drop && (drop_cnt != 8'hff)) begin
      drop_cnt <= drop_cnt + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fifo_wr_ctrl.sv
// Directed bench for fifo_wr_ctrl: a fill/occupancy model checked every cycle, plus literal expectations.
// Includes a behavioural write-pointer gray counter; WR_DROP_CNT_EN also checks drop_cnt.
module tb_fifo_wr_ctrl;
  localparam int SYNC = 2;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       ovf_clr = 1'b0;
  logic [8:0] rbin_drv = 9'd0;
  logic [8:0] rptr_gray_async;
  logic       full, almost_full, overflow;
  logic [8:0] wr_level;
`ifdef WR_DROP_CNT_EN
  logic [7:0] drop_cnt;
`endif

  int checks = 0;
  int failures = 0;

  fifo_wr_ctrl_if #(.ADDR_SIZE(8)) wif ();

  fifo_wr_ctrl #(.ADDR_SIZE(8), .AFULL_THRESH(240), .SYNC_STAGES(SYNC)) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .wr              (wif),
    .rptr_gray_async (rptr_gray_async),
    .ovf_clr         (ovf_clr),
    .full            (full),
    .almost_full     (almost_full),
    .wr_level        (wr_level),
    .overflow        (overflow)
`ifdef WR_DROP_CNT_EN
    ,
    .drop_cnt        (drop_cnt)
`endif
  );

  always #5 clk = ~clk;

  assign rptr_gray_async = rbin_drv ^ (rbin_drv >> 1);

  // Write-pointer counter sitting outside the controller
  logic [8:0] wcnt;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) wcnt <= 9'd0;
    else if (wif.cnt_en) wcnt <= wcnt + 9'd1;
  end
  assign wif.wptr_gray = wcnt ^ (wcnt >> 1);

  // Model: writes accepted, read pointer seen SYNC edges late, occupancy.
  int m_writes;
  int m_rhist [SYNC];
  int m_level;
  bit m_full, m_af, m_ovf;
  int m_drop;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_writes = 0; m_level = 0; m_full = 0; m_af = 0; m_ovf = 0; m_drop = 0;
      for (int i = 0; i < SYNC; i++) m_rhist[i] = 0;
    end else begin
      bit acc, drp;
      int seen;
      acc  = wif.wr_req && !m_full;
      drp  = wif.wr_req && m_full;
      seen = m_rhist[SYNC-1];
      m_writes = (m_writes + (acc ? 1 : 0)) % 512;
      m_level  = (m_writes - seen + 512) % 512;
      m_full   = (m_level == 256);
      m_af     = (m_level >= 240);
      if (drp) m_ovf = 1;
      else if (ovf_clr) m_ovf = 0;
      if (ovf_clr) m_drop = 0;
      else if (drp && m_drop < 255) m_drop = m_drop + 1;
      for (int i = SYNC - 1; i > 0; i--) m_rhist[i] = m_rhist[i-1];
      m_rhist[0] = int'(rbin_drv);
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model
  always @(negedge clk) begin
    if (reset_n) begin
      bit exp_acc;
      exp_acc = wif.wr_req && !m_full;
      chk("wr_ack", 32'(wif.wr_ack), 32'(exp_acc));
      chk("cnt_en", 32'(wif.cnt_en), 32'(exp_acc));
      chk("mem_we", 32'(wif.mem_we), 32'(exp_acc));
      if (exp_acc) begin
        chk("mem_waddr", 32'(wif.mem_waddr), 32'(m_writes % 256));
        chk("mem_wdata", 32'(wif.mem_wdata), 32'(wif.wr_data));
      end
      chk("full", 32'(full), 32'(m_full));
      chk("almost_full", 32'(almost_full), 32'(m_af));
      chk("wr_level", 32'(wr_level), 32'(m_level));
      chk("overflow", 32'(overflow), 32'(m_ovf));
`ifdef WR_DROP_CNT_EN
      chk("drop_cnt", 32'(drop_cnt), 32'(m_drop));
`endif
    end
  end

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic do_writes(input int n, input int a0);
    wif.wr_req = 1'b1;
    for (int i = 0; i < n; i++) begin
      wif.wr_data = 8'((a0 + i) ^ 8'h5a);
      @(negedge clk);
      chk("lit_wr_ack", 32'(wif.wr_ack), 32'd1);
      chk("lit_waddr", 32'(wif.mem_waddr), 32'((a0 + i) % 256));
      @(posedge clk); #1;
    end
    wif.wr_req = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    wif.wr_req  = 1'b0;
    wif.wr_data = 8'd0;
    idle(2);
    reset_n = 1'b1;
    idle(2);

    // 1: reset / idle
    @(negedge clk);
    chk("rst_full", 32'(full), 32'd0);
    chk("rst_af", 32'(almost_full), 32'd0);
    chk("rst_level", 32'(wr_level), 32'd0);
    chk("rst_ovf", 32'(overflow), 32'd0);
    chk("rst_cnt_en", 32'(wif.cnt_en), 32'd0);
    @(posedge clk); #1;

    // 2: 240 writes reach almost_full
    do_writes(240, 0);
    @(negedge clk);
    chk("af_level", 32'(wr_level), 32'd240);
    chk("af_af", 32'(almost_full), 32'd1);
    chk("af_full", 32'(full), 32'd0);
    @(posedge clk); #1;

    // 3: fill to 256, then one rejected request
    do_writes(16, 240);
    @(negedge clk);
    chk("full_full", 32'(full), 32'd1);
    chk("full_level", 32'(wr_level), 32'd256);
    @(posedge clk); #1;
    wif.wr_req = 1'b1;
    @(negedge clk);
    chk("rej_ack", 32'(wif.wr_ack), 32'd0);
    chk("rej_we", 32'(wif.mem_we), 32'd0);
    @(posedge clk); #1;
    wif.wr_req = 1'b0;
    @(negedge clk);
    chk("ovf_set", 32'(overflow), 32'd1);
`ifdef WR_DROP_CNT_EN
    chk("drop_one", 32'(drop_cnt), 32'd1);
`endif
    @(posedge clk); #1;

    // 4: one read frees a slot after SYNC+1 edges
    rbin_drv = 9'd1;
    idle(2);
    @(negedge clk);
    chk("rd_lat_full", 32'(full), 32'd1);
    @(posedge clk); #1;
    @(negedge clk);
    chk("rd_full", 32'(full), 32'd0);
    chk("rd_level", 32'(wr_level), 32'd255);
    @(posedge clk); #1;
    do_writes(1, 0);
    @(negedge clk);
    chk("refull", 32'(full), 32'd1);
    @(posedge clk); #1;

    // 6: set beats clear; clear alone clears
    wif.wr_req = 1'b1;
    ovf_clr    = 1'b1;
    idle(1);
    wif.wr_req = 1'b0;
    ovf_clr    = 1'b0;
    @(negedge clk);
    chk("ovf_set_wins", 32'(overflow), 32'd1);
`ifdef WR_DROP_CNT_EN
    chk("drop_clr_wins", 32'(drop_cnt), 32'd0);
`endif
    @(posedge clk); #1;
    ovf_clr = 1'b1;
    idle(1);
    ovf_clr = 1'b0;
    @(negedge clk);
    chk("ovf_clr", 32'(overflow), 32'd0);
    @(posedge clk); #1;

    // 5: pointer wrap 511 -> 0
    rbin_drv = 9'd257;
    idle(4);
    do_writes(253, 1);
    rbin_drv = 9'd510;
    idle(4);
    @(negedge clk);
    chk("wrap_pre_level", 32'(wr_level), 32'd0);
    @(posedge clk); #1;
    do_writes(4, 254);
    @(negedge clk);
    chk("wrap_level", 32'(wr_level), 32'd4);
    chk("wrap_full", 32'(full), 32'd0);
    @(posedge clk); #1;

    // Async reset in the middle of a burst
    do_writes(2, 2);
    @(negedge clk);
    chk("pre_rst_level", 32'(wr_level), 32'd6);
    @(posedge clk); #1;
    wif.wr_req = 1'b1;
    #2;
    reset_n    = 1'b0;
    wif.wr_req = 1'b0;
    rbin_drv   = 9'd0;
    #1;
    chk("arst_full", 32'(full), 32'd0);
    chk("arst_af", 32'(almost_full), 32'd0);
    chk("arst_level", 32'(wr_level), 32'd0);
    chk("arst_ovf", 32'(overflow), 32'd0);
    chk("arst_waddr", 32'(wif.mem_waddr), 32'd0);
    chk("arst_ack", 32'(wif.wr_ack), 32'd0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    idle(3);
    do_writes(3, 0);
    @(negedge clk);
    chk("post_rst_level", 32'(wr_level), 32'd3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
